// File: rtl/fluxo_dados_pkg.sv
// Shared game constants for the controller and datapath, plus the fixed
// contents of the sequence memory.
package fluxo_dados_pkg;

  localparam int TIMEOUT_CICLOS_PADRAO = 5000;
  localparam int MEM_PROF              = 16;
  localparam int DADO_W                = 4;
  localparam int ADDR_W                = $clog2(MEM_PROF);

  // Expected play for each round position; every entry is one-hot.
  function automatic logic [DADO_W-1:0] rom_dado(input logic [ADDR_W-1:0] endereco);
    logic [DADO_W-1:0] dado;
    dado = '0;
    case (endereco)
      4'd0:  dado = 4'h1;
      4'd1:  dado = 4'h2;
      4'd2:  dado = 4'h4;
      4'd3:  dado = 4'h8;
      4'd4:  dado = 4'h4;
      4'd5:  dado = 4'h2;
      4'd6:  dado = 4'h1;
      4'd7:  dado = 4'h1;
      4'd8:  dado = 4'h2;
      4'd9:  dado = 4'h2;
      4'd10: dado = 4'h4;
      4'd11: dado = 4'h4;
      4'd12: dado = 4'h8;
      4'd13: dado = 4'h8;
      4'd14: dado = 4'h1;
      4'd15: dado = 4'h4;
      default: dado = '0;
    endcase
    return dado;
  endfunction

endpackage

// File: rtl/fluxo_dados_rom.sv
// Read-only 16x4 sequence memory; the read is asynchronous despite the
// legacy module name.
module sync_rom_16x4
  import fluxo_dados_pkg::*;
(
  input  logic [ADDR_W-1:0] endereco,
  output logic [DADO_W-1:0] saida
);

  assign saida = rom_dado(endereco);

endmodule

// File: rtl/fluxo_dados.sv
// Game datapath: address/limit counters, play register, sequence memory,
// inactivity timeout and button press edge detector.
module fluxo_dados
  import fluxo_dados_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zeraC,
  input  logic       contaC,
  input  logic       zeraR,
  input  logic       registraR,
  input  logic       conta,
  input  logic       zeraCL,
  input  logic       contaCL,
  input  logic [3:0] botoes,
  output logic       igual,
  output logic       fimRodada,
  output logic       fimTotal,
  output logic       fimT,
  output logic       jogada,
  output logic [3:0] db_contagem,
  output logic [3:0] db_limite,
  output logic [3:0] db_jogada,
  output logic [3:0] db_memoria,
  output logic       db_tem_jogada
);

  // A one-cycle timeout still needs a 1-bit counter to hold the value 0.
  localparam int              TW    = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TW-1:0]   T_MAX = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [ADDR_W-1:0] CL_MAX = '1;

  logic [ADDR_W-1:0] c_q;
  logic [ADDR_W-1:0] cl_q;
  logic [DADO_W-1:0] r_q;
  logic [TW-1:0]     t_q;
  logic              s_prev_q;
  logic [DADO_W-1:0] mem_dado;
  logic              tem_jogada;

  assign tem_jogada = |botoes;

  sync_rom_16x4 u_rom (
    .endereco (c_q),
    .saida    (mem_dado)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_q      <= '0;
      cl_q     <= '0;
      r_q      <= '0;
      t_q      <= '0;
      s_prev_q <= 1'b0;
    end else begin
      if (zeraC)       c_q <= '0;
      else if (contaC) c_q <= c_q + 1'b1;

      if (zeraCL)                          cl_q <= '0;
      else if (contaCL && cl_q != CL_MAX)  cl_q <= cl_q + 1'b1;

      if (zeraR)          r_q <= '0;
      else if (registraR) r_q <= botoes;

      // Timeout only accumulates over an unbroken run of conta cycles.
      if (!conta)           t_q <= '0;
      else if (t_q != T_MAX) t_q <= t_q + 1'b1;

      s_prev_q <= tem_jogada;
    end
  end

  assign igual     = (r_q == mem_dado);
  assign fimRodada = (c_q == cl_q);
  assign fimTotal  = (cl_q == CL_MAX);
  assign fimT      = conta & (t_q == T_MAX);
  assign jogada    = tem_jogada & ~s_prev_q;

  assign db_contagem   = c_q;
  assign db_limite     = cl_q;
  assign db_jogada     = r_q;
  assign db_memoria    = mem_dado;
  assign db_tem_jogada = tem_jogada;

endmodule
